// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the program loader
// (LD), data load/store (DM) and instruction fetch (IF) requesters.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ld_*               loader write request, address, data, grant pulse
//   dm_*               data load/store request, payload, grant, read return
//   if_*               fetch read request, address, grant, read return
//   mem_*              memory macro address, strobes, write/read data
//   busy               high whenever the FSM is not in IDLE
//   region_err         sticky address-region violation flag
//
// Build option: define MEM_REGION_CHECK_EN to block IF accesses to the data
// region and DM accesses to the instruction region (region_err reports them).

module mem_port_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 16,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic          mem_re,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          region_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_LD, OWN_DM, OWN_IF} owner_t;

    state_t          state_q;
    owner_t          owner_q;
    owner_t          owner_d;
    logic [1:0]      lat_q;
    logic [SW-1:0]   starve_q;
    logic [SW-1:0]   starve_d;
    logic            ld_gnt_q;
    logic            dm_gnt_q;
    logic            if_gnt_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            mem_we_q;
    logic            mem_re_q;
    logic            rd_q;
    logic            viol_q;
    logic            viol_d;
    logic            dm_rvalid_q;
    logic            if_rvalid_q;
    logic [DW-1:0]   dm_hold_q;
    logic [DW-1:0]   if_hold_q;

    logic            any_req;
    logic            starved;
    logic            pick_ld;
    logic            pick_dm;
    logic            pick_if;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic            win_we;
    logic [DW-1:0]   rd_data;

    assign any_req = ld_req | dm_req | if_req;
    assign starved = (starve_q == STARVE_TOP);

    // A starved IF overtakes DM but never the loader.
    assign pick_ld = ld_req;
    assign pick_if = !ld_req && if_req && (!dm_req || starved);
    assign pick_dm = !ld_req && dm_req && !pick_if;

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        owner_d   = OWN_LD;
        if (pick_ld) begin
            win_addr  = ld_addr;
            win_wdata = ld_wdata;
            win_we    = 1'b1;
            owner_d   = OWN_LD;
        end else if (pick_dm) begin
            win_addr  = dm_addr;
            win_wdata = dm_wdata;
            win_we    = dm_we;
            owner_d   = OWN_DM;
        end else if (pick_if) begin
            win_addr  = if_addr;
            owner_d   = OWN_IF;
        end
    end

`ifdef MEM_REGION_CHECK_EN
    localparam logic [AW-1:0] DATA_BASE = AW'('h2000);
    logic region_err_q;

    assign viol_d = (pick_if && (if_addr >= DATA_BASE))
                 || (pick_dm && (dm_addr < DATA_BASE));

    always_ff @(posedge clk) begin
        if (rst) begin
            region_err_q <= 1'b0;
        end else if (state_q == IDLE && any_req && viol_d) begin
            region_err_q <= 1'b1;
        end
    end

    assign region_err = region_err_q;
`else
    assign viol_d     = 1'b0;
    assign region_err = 1'b0;
`endif

    // Starvation only advances while IF is waiting in IDLE and loses.
    always_comb begin
        starve_d = starve_q;
        if (!if_req) begin
            starve_d = '0;
        end else if (state_q == IDLE) begin
            if (pick_if) begin
                starve_d = '0;
            end else if (!starved) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_LD;
            lat_q       <= '0;
            starve_q    <= '0;
            ld_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            rd_q        <= 1'b0;
            viol_q      <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rvalid_q <= 1'b0;
            dm_hold_q   <= '0;
            if_hold_q   <= '0;
        end else begin
            ld_gnt_q    <= 1'b0;
            dm_gnt_q    <= 1'b0;
            if_gnt_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            dm_rvalid_q <= 1'b0;
            if_rvalid_q <= 1'b0;
            starve_q    <= starve_d;
            if (dm_rvalid_q) dm_hold_q <= dm_rdata;
            if (if_rvalid_q) if_hold_q <= if_rdata;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q     <= ISSUE;
                        owner_q     <= owner_d;
                        mem_addr_q  <= win_addr;
                        mem_wdata_q <= win_wdata;
                        rd_q        <= !win_we;
                        viol_q      <= viol_d;
                        mem_we_q    <= win_we && !viol_d;
                        mem_re_q    <= !win_we && !viol_d;
                        ld_gnt_q    <= pick_ld;
                        dm_gnt_q    <= pick_dm;
                        if_gnt_q    <= pick_if;
                    end
                end
                ISSUE: begin
                    if (rd_q) begin
                        state_q <= WAIT;
                        lat_q   <= LAT_INIT;
                        // rvalid is registered, so it is raised one
                        // cycle ahead of the final WAIT cycle.
                        if (LAT_INIT == 2'd0) begin
                            dm_rvalid_q <= (owner_q == OWN_DM);
                            if_rvalid_q <= (owner_q == OWN_IF);
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (lat_q == 2'd0) begin
                        state_q <= IDLE;
                    end else begin
                        lat_q <= lat_q - 2'd1;
                        if (lat_q == 2'd1) begin
                            dm_rvalid_q <= (owner_q == OWN_DM);
                            if_rvalid_q <= (owner_q == OWN_IF);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A blocked read still completes on time but returns zero.
    assign rd_data   = viol_q ? '0 : mem_rdata;

    assign ld_gnt    = ld_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_gnt    = if_gnt_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rvalid = if_rvalid_q;
    assign dm_rdata  = dm_rvalid_q ? rd_data : dm_hold_q;
    assign if_rdata  = if_rvalid_q ? rd_data : if_hold_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter (RD_LAT=1 main
// instance, RD_LAT=2 second instance for the mid-read reset scenario).
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ld_req, ld_gnt;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata, dm_rdata;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy, region_err;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .region_err(region_err)
    );

    logic          rst2, if_req2;
    logic [AW-1:0] if_addr2;
    logic          ld_gnt2, dm_gnt2, dm_rvalid2, if_gnt2, if_rvalid2;
    logic [DW-1:0] dm_rdata2, if_rdata2, mem_wdata2;
    logic [AW-1:0] mem_addr2;
    logic          mem_we2, mem_re2, busy2, region_err2;
    logic [DW-1:0] mem_rdata2;
    assign mem_rdata2 = 16'h0F0F;

    mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2), .STARVE_MAX(4)) u_dut2 (
        .clk(clk), .rst(rst2),
        .ld_req(1'b0), .ld_addr('0), .ld_wdata('0), .ld_gnt(ld_gnt2),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr('0), .dm_wdata('0),
        .dm_gnt(dm_gnt2), .dm_rvalid(dm_rvalid2), .dm_rdata(dm_rdata2),
        .if_req(if_req2), .if_addr(if_addr2), .if_gnt(if_gnt2),
        .if_rvalid(if_rvalid2), .if_rdata(if_rdata2),
        .mem_addr(mem_addr2), .mem_we(mem_we2), .mem_re(mem_re2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .busy(busy2), .region_err(region_err2)
    );

    // Memory model, read latency 1, preloaded during reset.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe;
    always @(posedge clk) begin
        if (rst) begin
            mem[14'h0010] <= 16'hABCD;
            mem[14'h0020] <= 16'h1111;
            mem[14'h2100] <= 16'h7777;
            rd_pipe       <= '0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) rd_pipe <= mem[mem_addr];
        end
    end
    assign mem_rdata = rd_pipe;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // kind: 0 LD gnt, 1 DM gnt, 2 IF gnt, 3 DM rvalid, 4 IF rvalid
    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic          we;
        logic          re;
        logic [DW-1:0] data;
        int            cyc;
    } ev_t;
    ev_t expq[$];

    function automatic ev_t mk(input int k, input logic [AW-1:0] a,
                               input logic we, input logic re,
                               input logic [DW-1:0] d, input int c);
        ev_t e;
        e.kind = k; e.addr = a; e.we = we; e.re = re; e.data = d; e.cyc = c;
        return e;
    endfunction

    bit            busy_chk = 0;
    bit            hold_if = 0, hold_dm = 0;
    logic [DW-1:0] hold_if_v, hold_dm_v;

    always @(negedge clk) begin
        if (!rst) begin
            int ng, nv, k;
            ev_t e;
            bit ok;
            logic [DW-1:0] rd;
            ng = int'(ld_gnt) + int'(dm_gnt) + int'(if_gnt);
            nv = int'(dm_rvalid) + int'(if_rvalid);
            if (busy_chk) begin
                chk("busy_drop", busy, 0);
                busy_chk = 0;
            end
            if (hold_if) begin
                if (!if_rvalid) chk("if_rdata_hold", if_rdata, hold_if_v);
                hold_if = 0;
            end
            if (hold_dm) begin
                if (!dm_rvalid) chk("dm_rdata_hold", dm_rdata, hold_dm_v);
                hold_dm = 0;
            end
            if (ng + nv > 1) chk("single_event", ng + nv, 1);
            if (ng == 0 && (mem_we || mem_re))
                chk("strobe_outside_issue", {mem_we, mem_re}, 0);
            if (ng + nv == 1) begin
                k = ld_gnt ? 0 : dm_gnt ? 1 : if_gnt ? 2 : dm_rvalid ? 3 : 4;
                if (expq.size() == 0) begin
                    chk("unexpected_event", k, 99);
                end else begin
                    e = expq.pop_front();
                    n_chk++;
                    if (k < 3) begin
                        ok = (k == e.kind) && (mem_addr == e.addr)
                          && (mem_we == e.we) && (mem_re == e.re)
                          && (!e.we || mem_wdata == e.data)
                          && (e.cyc < 0 || cyc == e.cyc);
                        if (mem_we) busy_chk = 1;
                        if (ok) n_pass++;
                        else $display("FAIL grant: got k=%0d a=%h we=%b re=%b wd=%h c=%0d want k=%0d a=%h we=%b re=%b wd=%h c=%0d",
                            k, mem_addr, mem_we, mem_re, mem_wdata, cyc,
                            e.kind, e.addr, e.we, e.re, e.data, e.cyc);
                    end else begin
                        rd = (k == 3) ? dm_rdata : if_rdata;
                        ok = (k == e.kind) && (rd == e.data)
                          && (e.cyc < 0 || cyc == e.cyc);
                        busy_chk = 1;
                        if (k == 3) begin hold_dm = 1; hold_dm_v = e.data; end
                        else begin hold_if = 1; hold_if_v = e.data; end
                        if (ok) n_pass++;
                        else $display("FAIL rvalid: got k=%0d d=%h c=%0d want k=%0d d=%h c=%0d",
                            k, rd, cyc, e.kind, e.data, e.cyc);
                    end
                end
            end
        end
    end

    int ld_left = 0, dm_left = 0, if_left = 0;

    // Drives the handshake: hold each req until its grant count is used
    // up, then drop it the cycle after the last grant.
    task automatic run(input int maxc);
        bit dld = 0, ddm = 0, dif = 0, done = 0;
        for (int n = 0; n < maxc && !done; n++) begin
            @(posedge clk); #1;
            if (dld) begin ld_req = 0; dld = 0; end
            if (ddm) begin dm_req = 0; ddm = 0; end
            if (dif) begin if_req = 0; dif = 0; end
            if (ld_gnt) begin ld_left--; if (ld_left == 0) dld = 1; end
            if (dm_gnt) begin dm_left--; if (dm_left == 0) ddm = 1; end
            if (if_gnt) begin if_left--; if (if_left == 0) dif = 1; end
            if (ld_left <= 0 && dm_left <= 0 && if_left <= 0
                && !dld && !ddm && !dif && !busy) done = 1;
        end
        if (!done) chk("run_timeout", 1, 0);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int c0;
        logic [DW-1:0] rv_exp;
        logic          re_exp, err_exp;
        rst = 1; rst2 = 1;
        ld_req = 0; ld_addr = '0; ld_wdata = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        if_req = 0; if_addr = '0; if_req2 = 0; if_addr2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_gnts", {ld_gnt, dm_gnt, if_gnt}, 0);
        chk("rst_strobes", {mem_we, mem_re}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rvalid", {dm_rvalid, if_rvalid}, 0);
        chk("rst_rdata", {dm_rdata, if_rdata}, 0);
        chk("rst_region_err", region_err, 0);
        step(); rst = 0;

        // IF-only read
        step(); c0 = cyc;
        if_addr = 14'h0010; if_req = 1; if_left = 1;
        expq.push_back(mk(2, 14'h0010, 0, 1, 0, c0 + 1));
        expq.push_back(mk(4, 0, 0, 0, 16'hABCD, c0 + 2));
        run(20);

        // DM store then load back
        step(); c0 = cyc;
        dm_addr = 14'h2004; dm_wdata = 16'h1234; dm_we = 1; dm_req = 1;
        dm_left = 1;
        expq.push_back(mk(1, 14'h2004, 1, 0, 16'h1234, c0 + 1));
        run(20);
        step(); c0 = cyc;
        dm_we = 0; dm_req = 1; dm_left = 1;
        expq.push_back(mk(1, 14'h2004, 0, 1, 0, c0 + 1));
        expq.push_back(mk(3, 0, 0, 0, 16'h1234, c0 + 2));
        run(20);

        // All three in the same cycle
        step(); c0 = cyc;
        ld_addr = 14'h2008; ld_wdata = 16'hBEEF; ld_req = 1; ld_left = 1;
        dm_addr = 14'h2008; dm_we = 0; dm_req = 1; dm_left = 1;
        if_addr = 14'h0020; if_req = 1; if_left = 1;
        expq.push_back(mk(0, 14'h2008, 1, 0, 16'hBEEF, c0 + 1));
        expq.push_back(mk(1, 14'h2008, 0, 1, 0, c0 + 3));
        expq.push_back(mk(3, 0, 0, 0, 16'hBEEF, c0 + 4));
        expq.push_back(mk(2, 14'h0020, 0, 1, 0, c0 + 6));
        expq.push_back(mk(4, 0, 0, 0, 16'h1111, c0 + 7));
        run(40);

        // DM and IF held: four DM wins, then IF, repeated
        step(); c0 = cyc;
        dm_addr = 14'h2010; dm_wdata = 16'h00AA; dm_we = 1; dm_req = 1;
        dm_left = 9;
        if_addr = 14'h0010; if_req = 1; if_left = 2;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                expq.push_back(mk(1, 14'h2010, 1, 0, 16'h00AA,
                                  c0 + 1 + 2 * k + 11 * r));
            expq.push_back(mk(2, 14'h0010, 0, 1, 0, c0 + 9 + 11 * r));
            expq.push_back(mk(4, 0, 0, 0, 16'hABCD, c0 + 10 + 11 * r));
        end
        expq.push_back(mk(1, 14'h2010, 1, 0, 16'h00AA, c0 + 23));
        run(80);

        // IF fetch from the data region
`ifdef MEM_REGION_CHECK_EN
        re_exp = 0; rv_exp = 16'h0000; err_exp = 1;
`else
        re_exp = 1; rv_exp = 16'h7777; err_exp = 0;
`endif
        step(); c0 = cyc;
        if_addr = 14'h2100; if_req = 1; if_left = 1;
        expq.push_back(mk(2, 14'h2100, 0, re_exp, 0, c0 + 1));
        expq.push_back(mk(4, 0, 0, 0, rv_exp, c0 + 2));
        run(20);
        @(negedge clk);
        chk("region_err_set", region_err, err_exp);
        step(); c0 = cyc;
        if_addr = 14'h0020; if_req = 1; if_left = 1;
        expq.push_back(mk(2, 14'h0020, 0, 1, 0, c0 + 1));
        expq.push_back(mk(4, 0, 0, 0, 16'h1111, c0 + 2));
        run(20);
        @(negedge clk);
        chk("region_err_held", region_err, err_exp);

        // Reset during WAIT of an RD_LAT=2 read
        step(); rst2 = 0;
        step(); if_addr2 = 14'h0030; if_req2 = 1;
        step(); @(negedge clk);
        chk("r2_gnt", {if_gnt2, mem_re2}, 2'b11);
        chk("r2_addr", mem_addr2, 14'h0030);
        step(); if_req2 = 0; rst2 = 1;
        @(negedge clk);
        chk("r2_wait_no_rvalid", if_rvalid2, 0);
        chk("r2_wait_busy", busy2, 1);
        step(); rst2 = 0;
        @(negedge clk);
        chk("r2_post_rst_rvalid", if_rvalid2, 0);
        chk("r2_post_rst_busy", busy2, 0);
        chk("r2_post_rst_mem", {mem_re2, mem_we2, mem_addr2}, 0);
        chk("r2_post_rst_rdata", if_rdata2, 0);
        chk("r2_post_rst_gnt", if_gnt2, 0);
        step(); if_addr2 = 14'h0031; if_req2 = 1;
        @(negedge clk);
        chk("r2_idle_no_rvalid", if_rvalid2, 0);
        step(); @(negedge clk);
        chk("r2_gnt2", {if_gnt2, mem_re2}, 2'b11);
        step(); if_req2 = 0;
        @(negedge clk);
        chk("r2_wait1", if_rvalid2, 0);
        step(); @(negedge clk);
        chk("r2_rvalid", if_rvalid2, 1);
        chk("r2_rdata", if_rdata2, 16'h0F0F);
        step(); @(negedge clk);
        chk("r2_after", {if_rvalid2, busy2}, 0);
        chk("r2_hold", if_rdata2, 16'h0F0F);

        // Reset clears the sticky flag
        step(); rst = 1;
        step(); @(negedge clk);
        chk("rst_clears_err", region_err, 0);
        chk("rst_busy2", busy, 0);
        chk("scoreboard_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between three requesters: program loader (LD), data load/store (DM) and instruction fetch (IF).
- Memory map: 14-bit word-addressed space; instruction region 0x0000–0x1FFF, data region 0x2000–0x3FFF.
- Sits between the processor core, the boot loader and the memory macro.
- Sequences each access through issue and read-latency phases, so the core never drives memory directly.

Parameters:
- AW, 14, memory address width.
- DW, 16, data width.
- RD_LAT, 1, memory read latency in cycles from the mem_re cycle to valid mem_rdata; legal range 1–3.
- STARVE_MAX, 4, number of consecutive lost arbitrations after which IF is promoted above DM.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ld_req  in  1  loader write request (level)
- ld_addr  in  AW  loader address
- ld_wdata  in  DW  loader write data
- ld_gnt  out  1  loader grant pulse
- dm_req  in  1  data request (level)
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  data grant pulse
- dm_rvalid  out  1  load data valid
- dm_rdata  out  DW  load data
- if_req  in  1  fetch request (level, read only)
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch grant pulse
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DW  fetch data
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in any state other than IDLE
- region_err  out  1  sticky address-region violation flag

Behaviour:
- Reset: state = IDLE, starvation counter = 0, latency counter = 0. All outputs are 0.
- Reset mid-operation: any outstanding read is discarded, with no rvalid afterwards.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: samples the req lines and picks a winner. With no request, the FSM stays in IDLE.
  - Winner payload (addr, we, wdata) is registered and the FSM goes to ISSUE in the next cycle.
- ISSUE (exactly 1 cycle): mem_addr, mem_wdata and mem_we/mem_re are driven from the registered payload, and the winner's gnt = 1.
  - Write: next state is IDLE.
  - Read: next state is WAIT.
- WAIT: lasts RD_LAT cycles. In the last WAIT cycle, the owner's rvalid = 1 and its rdata = mem_rdata (combinational pass-through); next state is IDLE.
  - The non-owner's rvalid stays 0. rdata holds its last value when rvalid = 0.
- Latency (RD_LAT = 1):
  - Read: req seen in IDLE at cycle N; gnt/mem_re at N+1; rvalid at N+2; next arbitration at N+3.
  - Write: gnt/mem_we at N+1; next arbitration at N+2.
- Handshake:
  - req and payload must stay stable from assertion until the cycle gnt is high.
  - The requester deasserts req the cycle after gnt unless it is presenting a new request.
  - At most one access is outstanding at any time.
- Priority: LD > DM > IF.
  - Starvation counter increments in each IDLE cycle where if_req = 1 and IF loses.
  - The counter clears when IF is granted or if_req = 0.
  - When the counter equals STARVE_MAX, IF beats DM (never LD). The counter saturates at STARVE_MAX.
- Simultaneous requests are resolved only in IDLE. Requests arriving during ISSUE/WAIT wait for the next IDLE.
- mem_we and mem_re are never both high. Both are 0 outside ISSUE.
- Address width is exactly AW; there is no wrap logic, and addresses pass unchanged.

Optional Feature:
- Macro: MEM_REGION_CHECK_EN.
- With the macro defined:
  - An IF request with addr ≥ 0x2000, or a DM request with addr < 0x2000, is granted normally, but mem_we/mem_re stay 0 in ISSUE.
  - A violating read returns rvalid with rdata = 0x0000 at the normal time.
  - region_err is set and stays high until rst.
  - LD is never checked.
- Without the macro: no checking is done, and region_err is tied 0.

Test Plan:
- IF only, if_addr = 0x0010, mem returns 0xABCD:
  - if_gnt and mem_re with mem_addr = 0x0010 one cycle after the req is seen; if_rvalid with if_rdata = 0xABCD one cycle later.
- DM store, dm_addr = 0x2004, dm_wdata = 0x1234:
  - mem_we = 1, mem_addr = 0x2004, mem_wdata = 0x1234, dm_gnt for exactly 1 cycle; busy drops the next cycle.
- ld_req, dm_req and if_req all asserted in the same cycle:
  - grant order LD, DM, IF; no overlapping gnt; each grant separated by the correct state sequence.
- dm_req and if_req held continuously, STARVE_MAX = 4:
  - DM wins 4 arbitrations, then IF wins the 5th; counter clears; pattern repeats.
- rst asserted during WAIT of an IF read (RD_LAT = 2):
  - no if_rvalid; all outputs 0 the next cycle; first post-reset request is serviced normally.
- MEM_REGION_CHECK_EN defined, if_addr = 0x2100:
  - if_gnt with mem_re = 0; if_rvalid with if_rdata = 0x0000; region_err = 1 and held until rst.
